control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/sap1_pkg.sv | 73 +++++++
 rtl/control_sequencer_ring_counter.sv | 65 ++++++
 rtl/control_sequencer.sv | 128 ++++++++++++
 tb/tb_control_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/sap1_pkg.sv
// sap1_pkg
// Shared definitions for the SAP-1 control sequencer: opcode encodings,
// T-state encoding, the packed control word and its all-inactive value,
// plus a helper that maps a state to its one-hot T-state display.
package sap1_pkg;

    typedef enum logic [3:0] {
        OP_LDA = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_e;

    typedef enum logic [2:0] {
        ST_T1   = 3'd0,
        ST_T2   = 3'd1,
        ST_T3   = 3'd2,
        ST_T4   = 3'd3,
        ST_T5   = 3'd4,
        ST_T6   = 3'd5,
        ST_HALT = 3'd6
    } state_e;

    localparam int unsigned NUM_TSTATES = 6;

    typedef struct packed {
        logic pc_inc;
        logic pc_en;
        logic mar_load_n;
        logic ram_en_n;
        logic ir_load_n;
        logic ir_en_n;
        logic a_load_n;
        logic a_en;
        logic alu_sub;
        logic alu_en;
        logic b_load_n;
        logic out_load_n;
    } ctrl_word_t;

    // Active-low strobes idle high, active-high strobes idle low.
    localparam ctrl_word_t CTRL_INACTIVE = '{
        pc_inc:     1'b0,
        pc_en:      1'b0,
        mar_load_n: 1'b1,
        ram_en_n:   1'b1,
        ir_load_n:  1'b1,
        ir_en_n:    1'b1,
        a_load_n:   1'b1,
        a_en:       1'b0,
        alu_sub:    1'b0,
        alu_en:     1'b0,
        b_load_n:   1'b1,
        out_load_n: 1'b1
    };

    function automatic logic [NUM_TSTATES-1:0] tstate_onehot(input state_e s);
        logic [NUM_TSTATES-1:0] t;
        t = '0;
        case (s)
            ST_T1:   t = 6'b000001;
            ST_T2:   t = 6'b000010;
            ST_T3:   t = 6'b000100;
            ST_T4:   t = 6'b001000;
            ST_T5:   t = 6'b010000;
            ST_T6:   t = 6'b100000;
            default: t = '0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/control_sequencer_ring_counter.sv
// ring_counter
// T-state register for the control sequencer. Steps T1..T6 while run is
// high, freezes while run is low, and parks in HALT when a halt request is
// seen in T4. HALT is left only through reset.
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset, forces T1
//   run      in   1 = advance one T-state per clock
//   hlt_req  in   decoded HLT opcode, honoured only in T4
//   state    out  current state
//   tstate   out  one-hot T-state, zero in HALT
//   halted   out  high in HALT
//
// state   | meaning
// --------+----------------------------------------------
// ST_T1   | fetch: PC onto bus, load MAR
// ST_T2   | fetch: increment PC
// ST_T3   | fetch: RAM onto bus, load IR
// ST_T4   | execute step 1 (HLT leaves to HALT from here)
// ST_T5   | execute step 2
// ST_T6   | execute step 3, then back to T1
// ST_HALT | stopped, outputs inactive until reset
module ring_counter
    import sap1_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic                   hlt_req,
    output state_e                 state,
    output logic [NUM_TSTATES-1:0] tstate,
    output logic                   halted
);

    state_e state_q;
    state_e state_d;

    always_comb begin
        state_d = state_q;
        if (run && (state_q != ST_HALT)) begin
            case (state_q)
                ST_T1:   state_d = ST_T2;
                ST_T2:   state_d = ST_T3;
                ST_T3:   state_d = ST_T4;
                ST_T4:   state_d = hlt_req ? ST_HALT : ST_T5;
                ST_T5:   state_d = ST_T6;
                ST_T6:   state_d = ST_T1;
                // unused encoding: recover into a clean fetch
                default: state_d = ST_T1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_T1;
        end else begin
            state_q <= state_d;
        end
    end

    assign state  = state_q;
    assign tstate = tstate_onehot(state_q);
    assign halted = (state_q == ST_HALT);

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer
// SAP-1 style microcode sequencer. The ring_counter sub-module owns the
// T-state register; this module decodes the control word from the current
// state, the opcode and run.
//   clk, rst                 clock and synchronous active-high reset
//   run                      1 = advance, 0 = freeze with controls inactive
//   opcode[3:0]              upper nibble of the instruction register
//   pc_inc, pc_en            program counter increment / bus drive
//   mar_load_n               MAR load (active-low)
//   ram_en_n                 RAM bus drive (active-low)
//   ir_load_n, ir_en_n       IR load / operand drive (active-low)
//   a_load_n, a_en           accumulator load (active-low) / drive
//   alu_sub, alu_en          ALU subtract select / bus drive
//   b_load_n, out_load_n     B and output register loads (active-low)
//   tstate[5:0], halted      one-hot T-state and halt indication
module control_sequencer
    import sap1_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [3:0] opcode,
    output logic       pc_inc,
    output logic       pc_en,
    output logic       mar_load_n,
    output logic       ram_en_n,
    output logic       ir_load_n,
    output logic       ir_en_n,
    output logic       a_load_n,
    output logic       a_en,
    output logic       alu_sub,
    output logic       alu_en,
    output logic       b_load_n,
    output logic       out_load_n,
    output logic [5:0] tstate,
    output logic       halted
);

    state_e     state;
    opcode_e    op;
    ctrl_word_t ctrl;
    logic       hlt_req;

    assign op      = opcode_e'(opcode);
    assign hlt_req = (op == OP_HLT);

    ring_counter u_ring_counter (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .hlt_req (hlt_req),
        .state   (state),
        .tstate  (tstate),
        .halted  (halted)
    );

    // Opcode is only consulted in T4..T6, so IR contents during fetch
    // cannot disturb the fetch cycle. HALT falls into the default arm.
    always_comb begin
        ctrl = CTRL_INACTIVE;
        if (run) begin
            case (state)
                ST_T1: begin
                    ctrl.pc_en      = 1'b1;
                    ctrl.mar_load_n = 1'b0;
                end
                ST_T2: begin
                    ctrl.pc_inc = 1'b1;
                end
                ST_T3: begin
                    ctrl.ram_en_n  = 1'b0;
                    ctrl.ir_load_n = 1'b0;
                end
                ST_T4: begin
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ctrl.ir_en_n    = 1'b0;
                            ctrl.mar_load_n = 1'b0;
                        end
                        OP_OUT: begin
                            ctrl.a_en       = 1'b1;
                            ctrl.out_load_n = 1'b0;
                        end
                        default: ;
                    endcase
                end
                ST_T5: begin
                    case (op)
                        OP_LDA: begin
                            ctrl.ram_en_n = 1'b0;
                            ctrl.a_load_n = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            ctrl.ram_en_n = 1'b0;
                            ctrl.b_load_n = 1'b0;
                        end
                        default: ;
                    endcase
                end
                ST_T6: begin
                    case (op)
                        OP_ADD, OP_SUB: begin
                            ctrl.alu_en   = 1'b1;
                            ctrl.a_load_n = 1'b0;
                            ctrl.alu_sub  = (op == OP_SUB);
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign pc_inc     = ctrl.pc_inc;
    assign pc_en      = ctrl.pc_en;
    assign mar_load_n = ctrl.mar_load_n;
    assign ram_en_n   = ctrl.ram_en_n;
    assign ir_load_n  = ctrl.ir_load_n;
    assign ir_en_n    = ctrl.ir_en_n;
    assign a_load_n   = ctrl.a_load_n;
    assign a_en       = ctrl.a_en;
    assign alu_sub    = ctrl.alu_sub;
    assign alu_en     = ctrl.alu_en;
    assign b_load_n   = ctrl.b_load_n;
    assign out_load_n = ctrl.out_load_n;

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer. A reference model predicts state and
// control word for each cycle; the prediction is queued when inputs are
// driven and popped when the DUT outputs are sampled mid-cycle.
module tb_control_sequencer;

    logic       clk;
    logic       rst;
    logic       run;
    logic [3:0] opcode;
    logic       pc_inc, pc_en, mar_load_n, ram_en_n, ir_load_n, ir_en_n;
    logic       a_load_n, a_en, alu_sub, alu_en, b_load_n, out_load_n;
    logic [5:0] tstate;
    logic       halted;

    control_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .opcode     (opcode),
        .pc_inc     (pc_inc),
        .pc_en      (pc_en),
        .mar_load_n (mar_load_n),
        .ram_en_n   (ram_en_n),
        .ir_load_n  (ir_load_n),
        .ir_en_n    (ir_en_n),
        .a_load_n   (a_load_n),
        .a_en       (a_en),
        .alu_sub    (alu_sub),
        .alu_en     (alu_en),
        .b_load_n   (b_load_n),
        .out_load_n (out_load_n),
        .tstate     (tstate),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control vector order: pc_inc pc_en mar_load_n ram_en_n ir_load_n
    // ir_en_n a_load_n a_en alu_sub alu_en b_load_n out_load_n
    localparam logic [11:0] M_PCINC  = 12'h800;
    localparam logic [11:0] M_PCEN   = 12'h400;
    localparam logic [11:0] M_MAR    = 12'h200;
    localparam logic [11:0] M_RAM    = 12'h100;
    localparam logic [11:0] M_IRL    = 12'h080;
    localparam logic [11:0] M_IRE    = 12'h040;
    localparam logic [11:0] M_AL     = 12'h020;
    localparam logic [11:0] M_AEN    = 12'h010;
    localparam logic [11:0] M_ALUSUB = 12'h008;
    localparam logic [11:0] M_ALUEN  = 12'h004;
    localparam logic [11:0] M_BL     = 12'h002;
    localparam logic [11:0] M_OUTL   = 12'h001;
    localparam logic [11:0] IDLE     = 12'h3E3;

    int n_cmp = 0;
    int n_bad = 0;
    int mstate = 0;            // 0..5 = T1..T6, 6 = HALT
    logic [18:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (model state %0d)", tag, obs, exp, mstate);
        end
    endtask

    function automatic logic [11:0] exp_ctrl(input int st, input logic rv, input logic [3:0] op);
        logic [11:0] act;
        act = '0;
        if (rv && st < 6) begin
            if (st == 0) act = M_PCEN | M_MAR;
            else if (st == 1) act = M_PCINC;
            else if (st == 2) act = M_RAM | M_IRL;
            else if (st == 3) begin
                if (op == 4'h0 || op == 4'h1 || op == 4'h2) act = M_IRE | M_MAR;
                else if (op == 4'hE) act = M_AEN | M_OUTL;
            end else if (st == 4) begin
                if (op == 4'h0) act = M_RAM | M_AL;
                else if (op == 4'h1 || op == 4'h2) act = M_RAM | M_BL;
            end else begin
                if (op == 4'h1) act = M_ALUEN | M_AL;
                else if (op == 4'h2) act = M_ALUEN | M_AL | M_ALUSUB;
            end
        end
        return IDLE ^ act;
    endfunction

    function automatic logic [5:0] exp_tstate(input int st);
        logic [5:0] t;
        t = '0;
        if (st < 6) t[st] = 1'b1;
        return t;
    endfunction

    // One clock cycle: drive inputs, queue prediction, compare, then advance the model.
    task automatic step(input logic r, input logic rv, input logic [3:0] op);
        logic [18:0] e;
        logic [11:0] obs_ctrl;
        int drivers;
        rst = r;
        run = rv;
        // fetch must ignore the opcode, so feed it noise there
        opcode = (mstate < 3) ? 4'($urandom_range(0, 15)) : op;
        exp_q.push_back({exp_ctrl(mstate, rv, opcode), exp_tstate(mstate), (mstate == 6)});
        #1;
        obs_ctrl = {pc_inc, pc_en, mar_load_n, ram_en_n, ir_load_n, ir_en_n,
                    a_load_n, a_en, alu_sub, alu_en, b_load_n, out_load_n};
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("ctrl", {20'd0, obs_ctrl}, {20'd0, e[18:7]});
            check("tstate", {26'd0, tstate}, {26'd0, e[6:1]});
            check("halted", {31'd0, halted}, {31'd0, e[0]});
        end
        drivers = int'(pc_en) + int'(!ram_en_n) + int'(!ir_en_n) + int'(a_en) + int'(alu_en);
        check("bus_drivers_le1", {31'd0, (drivers <= 1)}, 32'd1);
        @(posedge clk);
        if (r) mstate = 0;
        else if (mstate != 6 && rv) begin
            if (mstate == 3 && opcode == 4'hF) mstate = 6;
            else mstate = (mstate + 1) % 6;
        end
        @(negedge clk);
    endtask

    task automatic run_instr(input logic [3:0] op);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, op);
    endtask

    initial begin
        logic [3:0] ops [5];
        ops[0] = 4'h0; ops[1] = 4'h1; ops[2] = 4'h2; ops[3] = 4'hE; ops[4] = 4'h5;
        rst = 1'b1;
        run = 1'b1;
        opcode = 4'h0;
        @(posedge clk);
        mstate = 0;
        @(negedge clk);

        // full instruction cycles for each opcode class
        run_instr(4'h0);
        run_instr(4'h2);
        run_instr(4'h1);
        run_instr(4'hE);
        run_instr(4'h5);

        // freeze in T3 for four cycles, then resume
        step(1'b0, 1'b1, 4'h0);
        step(1'b0, 1'b1, 4'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'h0);

        // random run toggling over non-halting opcodes
        for (int i = 0; i < 24; i++) step(1'b0, 1'($urandom_range(0, 1)), ops[$urandom_range(0, 4)]);
        for (int i = 0; i < 6 && mstate != 0; i++) step(1'b0, 1'b1, 4'h0);
        check("back_in_t1", 32'(mstate), 32'd0);

        // reset during T5 of ADD aborts the instruction
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'h1);
        step(1'b1, 1'b1, 4'h1);
        step(1'b0, 1'b1, 4'h1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'h1);

        // HLT: enter HALT after T4, ignore run, leave only through reset
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'hF);
        for (int i = 0; i < 10; i++) step(1'b0, 1'(i % 2), 4'($urandom_range(0, 15)));
        step(1'b1, 1'b0, 4'hF);
        step(1'b0, 1'b1, 4'hF);
        step(1'b0, 1'b0, 4'h0);
        run_instr(4'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
